// File: rtl/adc_multi_capture_pkg.sv
// Shared constants and types for the multi-channel ADC capture block:
// register map, CTRL/STATUS bit positions, DATA word layout and scan FSM states.
package adc_multi_capture_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_DECIM  = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_DATA   = 3'd3;
    localparam logic [2:0] ADDR_THRESH = 3'd4;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int CTRL_MASK_LSB = 16;

    localparam int ST_LEVEL_W   = 16;
    localparam int ST_EMPTY_BIT = 16;
    localparam int ST_FULL_BIT  = 17;
    localparam int ST_OVF_BIT   = 18;
    localparam int ST_OVR_BIT   = 19;

    localparam int DATA_CH_LSB = 24;
    localparam int DATA_CH_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cap_state_e;

endpackage

// File: rtl/adc_cap_fifo.sv
// Synchronous FIFO for channel-tagged samples. A push while full is dropped even
// if a pop happens in the same cycle; flush empties it in one cycle.
module adc_cap_fifo #(
    parameter int DEPTH = 256,
    parameter int W     = 20
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/adc_multi_capture.sv
// NCH-channel ADC capture with decimation, channel mask and tagged FIFO behind an
// Avalon-MM slave. Define ADC_MULTI_CAPTURE_IRQ_EN to add THRESH and the level/sticky irq.
module adc_multi_capture
    import adc_multi_capture_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int ADC_W   = 12,
    parameter int DEPTH   = 256,
    parameter int DECIM_W = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [NCH*ADC_W-1:0] adc_data,
    input  logic                 adc_valid,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq
);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW   = DATA_CH_W + ADC_W;
    localparam int LW   = $clog2(DEPTH) + 1;

    cap_state_e           state_q;
    logic                 ctrl_en_q;
    logic [NCH-1:0]       mask_q;
    logic [DECIM_W-1:0]   decim_q;
    logic [DECIM_W-1:0]   cnt_q;
    logic [IDXW-1:0]      idx_q;
    logic [NCH*ADC_W-1:0] snap_q;
    logic [NCH-1:0]       snap_mask_q;
    logic                 ovf_q;
    logic                 ovr_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rdata_d;

    logic          wr_ctrl, wr_status, clear, en_rise;
    logic          capture, push, pop, ovf_set, ovr_set;
    logic [FW-1:0] push_data, fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;
    logic          unused_wd;

    assign unused_wd = ^avs_writedata;

    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);
    assign clear     = wr_ctrl && avs_writedata[CTRL_CLR_BIT];
    assign en_rise   = wr_ctrl && avs_writedata[CTRL_EN_BIT] && !ctrl_en_q;

    assign capture   = (state_q == IDLE) && adc_valid && ctrl_en_q && (cnt_q == '0);
    assign push      = (state_q == SCAN) && snap_mask_q[idx_q];
    assign push_data = {DATA_CH_W'(idx_q), snap_q[idx_q*ADC_W +: ADC_W]};
    assign pop       = avs_read && (avs_address == ADDR_DATA) && !fifo_empty;
    assign ovf_set   = push && fifo_full;
    assign ovr_set   = (state_q == SCAN) && adc_valid;

    adc_cap_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .flush_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_data),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef ADC_MULTI_CAPTURE_IRQ_EN
    logic [15:0] thresh_q;
    logic        irq_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (avs_write && (avs_address == ADDR_THRESH)) thresh_q <= avs_writedata[15:0];
            irq_q <= ((thresh_q != '0) && (32'(fifo_level) >= 32'(thresh_q))) || ovf_q || ovr_q;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                ADDR_CTRL: begin
                    rdata_d[CTRL_EN_BIT]              = ctrl_en_q;
                    rdata_d[CTRL_MASK_LSB +: NCH]     = mask_q;
                end
                ADDR_DECIM:  rdata_d[DECIM_W-1:0] = decim_q;
                ADDR_STATUS: begin
                    rdata_d[ST_LEVEL_W-1:0] = ST_LEVEL_W'(fifo_level);
                    rdata_d[ST_EMPTY_BIT]   = fifo_empty;
                    rdata_d[ST_FULL_BIT]    = fifo_full;
                    rdata_d[ST_OVF_BIT]     = ovf_q;
                    rdata_d[ST_OVR_BIT]     = ovr_q;
                end
                ADDR_DATA: begin
                    if (!fifo_empty) begin
                        rdata_d[DATA_CH_LSB +: DATA_CH_W] = fifo_rdata[FW-1:ADC_W];
                        rdata_d[ADC_W-1:0]                = fifo_rdata[ADC_W-1:0];
                    end
                end
`ifdef ADC_MULTI_CAPTURE_IRQ_EN
                ADDR_THRESH: rdata_d[15:0] = thresh_q;
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            ctrl_en_q   <= 1'b0;
            mask_q      <= '0;
            decim_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            snap_mask_q <= '0;
            ovf_q       <= 1'b0;
            ovr_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rdata_q <= rdata_d;
            if (wr_ctrl) begin
                ctrl_en_q <= avs_writedata[CTRL_EN_BIT];
                mask_q    <= avs_writedata[CTRL_MASK_LSB +: NCH];
            end
            if (avs_write && (avs_address == ADDR_DECIM)) decim_q <= avs_writedata[DECIM_W-1:0];

            if (clear) begin
                state_q <= IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                // A sticky event in the same cycle as its W1C write wins.
                if (ovf_set) ovf_q <= 1'b1;
                else if (wr_status && avs_writedata[ST_OVF_BIT]) ovf_q <= 1'b0;
                if (ovr_set) ovr_q <= 1'b1;
                else if (wr_status && avs_writedata[ST_OVR_BIT]) ovr_q <= 1'b0;

                case (state_q)
                    IDLE: begin
                        if (capture) begin
                            cnt_q       <= decim_q;
                            snap_mask_q <= mask_q;
                            idx_q       <= '0;
                            state_q     <= SCAN;
                        end else if (adc_valid && ctrl_en_q) begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    SCAN: begin
                        if (idx_q == IDXW'(NCH - 1)) state_q <= IDLE;
                        else                         idx_q   <= idx_q + 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase

                if (en_rise) cnt_q <= '0;
            end
        end
    end

    // Sample snapshot is pure data; validity is tracked by the FSM.
    always_ff @(posedge clk_clk) begin
        if (capture && !clear) snap_q <= adc_data;
    end

    assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_adc_multi_capture.sv
// Self-checking bench for adc_multi_capture (NCH=4, ADC_W=12, DEPTH=8); IRQ checks
// follow ADC_MULTI_CAPTURE_IRQ_EN.
module tb_adc_multi_capture;
    import adc_multi_capture_pkg::*;

    localparam int NCH = 4, ADC_W = 12, DEPTH = 8, DECIM_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [47:0] data;
        logic [3:0]  mask;
        int          exp_level;
    } vec_t;
    vec_t vecs[4];

    adc_multi_capture #(.NCH(NCH), .ADC_W(ADC_W), .DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic strobe(input logic [47:0] d);
        adc_data = d; adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    function automatic logic [31:0] st(input int lvl, input logic ovf, input logic ovr);
        logic [31:0] s;
        s = 32'(lvl);
        s[16] = (lvl == 0);
        s[17] = (lvl == DEPTH);
        s[18] = ovf;
        s[19] = ovr;
        return s;
    endfunction

    function automatic void model_capture(input logic [47:0] d, input logic [3:0] m);
        for (int k = 0; k < NCH; k++) begin
            if (m[k] && sb.size() < DEPTH)
                sb.push_back((32'(k) << 24) | 32'(d[k*ADC_W +: ADC_W]));
        end
    endfunction

    function automatic logic [47:0] mk(input int i);
        logic [11:0] v;
        v = 12'(i);
        return {12'hC00 | v, 12'h800 | v, 12'h400 | v, v};
    endfunction

    task automatic drain(input string tag);
        logic [31:0] d, e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(ADDR_DATA, d);
            chk({tag, "_data"}, d, e);
        end
    endtask

    task automatic ctrl(input logic clr, input logic [3:0] m);
        wr(ADDR_CTRL, (32'(m) << 16) | (32'(clr) << 1) | 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        vecs[0] = '{48'hABC789456123, 4'hF, 4};
        vecs[1] = '{48'hFFF000800001, 4'hA, 2};
        vecs[2] = '{48'h111222333444, 4'h0, 0};
        vecs[3] = '{48'h00A00B00C00D, 4'h1, 1};

        tick(3);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        tick(2);
        rd(ADDR_CTRL, d);   chk("rst_ctrl", d, 32'h0);
        rd(ADDR_DECIM, d);  chk("rst_decim", d, 32'h0);
        rd(ADDR_STATUS, d); chk("rst_status", d, st(0, 0, 0));
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, d);        chk("unmapped5", d, 32'h0);
        rd(3'd7, d);        chk("unmapped7", d, 32'h0);

        for (int v = 0; v < 4; v++) begin
            ctrl(1'b1, vecs[v].mask);
            rd(ADDR_CTRL, d);
            chk("ctrl_rb", d, (32'(vecs[v].mask) << 16) | 32'd1);
            strobe(vecs[v].data);
            model_capture(vecs[v].data, vecs[v].mask);
            tick(5);
            rd(ADDR_STATUS, d);
            chk("vec_level", d, st(vecs[v].exp_level, 0, 0));
            drain("vec");
            rd(ADDR_STATUS, d);
            chk("vec_empty", d, st(0, 0, 0));
        end

        // Decimation with mask 0x5
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_CTRL, 32'h2);
        wr(ADDR_DECIM, 32'd2);
        rd(ADDR_DECIM, d); chk("decim_rb", d, 32'd2);
        ctrl(1'b0, 4'h5);
        for (int i = 0; i < 9; i++) begin
            strobe(mk(i));
            if (i % 3 == 0) model_capture(mk(i), 4'h5);
            tick(5);
        end
        rd(ADDR_STATUS, d); chk("decim_level", d, st(6, 0, 0));
        drain("decim");
        wr(ADDR_DECIM, 32'd0);

        // Overrun: strobes on two consecutive cycles
        ctrl(1'b1, 4'hF);
        adc_data = mk(20); adc_valid = 1'b1;
        tick(1);
        adc_data = mk(21);
        tick(1);
        adc_valid = 1'b0;
        model_capture(mk(20), 4'hF);
        tick(4);
        rd(ADDR_STATUS, d); chk("ovr_set", d, st(4, 0, 1));
        wr(ADDR_STATUS, 32'h0008_0000);
        rd(ADDR_STATUS, d); chk("ovr_w1c", d, st(4, 0, 0));
        drain("ovr");

        // Overflow: three captures into an 8-deep FIFO
        ctrl(1'b1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            strobe(mk(40 + i));
            model_capture(mk(40 + i), 4'hF);
            tick(5);
        end
        rd(ADDR_STATUS, d); chk("ovf_full", d, st(8, 1, 0));
        drain("ovf");
        rd(ADDR_STATUS, d); chk("ovf_sticky", d, st(0, 1, 0));
        wr(ADDR_STATUS, 32'h0004_0000);
        rd(ADDR_STATUS, d); chk("ovf_w1c", d, st(0, 0, 0));

        // Pop while the scan is pushing, then read on empty
        ctrl(1'b1, 4'hF);
        strobe(mk(60));
        model_capture(mk(60), 4'hF);
        tick(1);
        rd(ADDR_DATA, d); chk("pp_data0", d, sb.pop_front());
        rd(ADDR_DATA, d); chk("pp_data1", d, sb.pop_front());
        tick(1);
        rd(ADDR_STATUS, d); chk("pp_level", d, st(2, 0, 0));
        drain("pp");
        rd(ADDR_DATA, d);   chk("empty_data", d, 32'h0);
        rd(ADDR_STATUS, d); chk("empty_level", d, st(0, 0, 0));

        // Threshold irq and clear during a scan
        ctrl(1'b1, 4'hF);
        wr(ADDR_THRESH, 32'd3);
        rd(ADDR_THRESH, d);
`ifdef ADC_MULTI_CAPTURE_IRQ_EN
        chk("thresh_rb", d, 32'd3);
`else
        chk("thresh_rb", d, 32'd0);
`endif
        strobe(mk(80));
        tick(3);
        chk("irq_below", 32'(irq), 32'd0);
        tick(1);
`ifdef ADC_MULTI_CAPTURE_IRQ_EN
        chk("irq_at_thresh", 32'(irq), 32'd1);
`else
        chk("irq_at_thresh", 32'(irq), 32'd0);
`endif
        strobe(mk(81));
        ctrl(1'b1, 4'hF);
        tick(1);
        chk("irq_after_clr", 32'(irq), 32'd0);
        rd(ADDR_STATUS, d); chk("clr_level", d, st(0, 0, 0));
        tick(5);
        rd(ADDR_STATUS, d); chk("clr_idle", d, st(0, 0, 0));
        sb.delete();

        // Asynchronous reset in the middle of a scan
        strobe(mk(90));
        tick(1);
        rst_n = 1'b0;
        #2;
        chk("arst_readdata", avs_readdata, 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        rd(ADDR_STATUS, d); chk("arst_status", d, st(0, 0, 0));
        rd(ADDR_CTRL, d);   chk("arst_ctrl", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_multi_capture.md
Name: adc_multi_capture

Overview:
- Parametrised successor to the single 12-bit ADC value PIO exported to the HPS.
- Captures NCH parallel ADC channels on a sample strobe, with programmable decimation and a per-channel enable mask.
- Serialises enabled channels into a channel-tagged FIFO.
- Exposes control, status and FIFO pop through an Avalon-MM slave on the HPS lightweight bridge.

Parameters:
- NCH, 4, channel count (1..16).
- ADC_W, 12, sample width per channel (1..24).
- DEPTH, 256, FIFO entries (power of 2, >=4).
- DECIM_W, 16, decimation counter width (<=16).

Ports:
- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- adc_data  in  NCH*ADC_W  channel k at bits [k*ADC_W +: ADC_W].
- adc_valid  in  1  one-cycle sample strobe; adc_data is valid in the same cycle.
- avs_address  in  3  word address.
- avs_read  in  1  Avalon read.
- avs_write  in  1  Avalon write.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; fixed read latency of 1 cycle.
- irq  out  1  level interrupt.

Behaviour:
- Reset values: avs_readdata=0, irq=0, FIFO empty, FSM=IDLE, all registers and stickies 0. Reset is fully asynchronous, including mid-scan; partial scans are discarded.
- Register map:
  - 0 CTRL (RW): bit0 enable; bit1 clear (write-1, self-clearing, reads 0); bits[16+NCH-1:16] channel mask.
  - 1 DECIM (RW): [DECIM_W-1:0]; capture every (DECIM+1)th adc_valid.
  - 2 STATUS (RO, W1C stickies):
    - [15:0] FIFO level.
    - bit16 empty; bit17 full.
    - bit18 overflow sticky; bit19 overrun sticky.
    - Writing 1 to bit18/bit19 clears that sticky.
  - 3 DATA (RO): a read pops one entry. Format [31:24]=channel index, [ADC_W-1:0]=sample, all other bits 0. Read while empty returns 0 and does not pop.
  - 4 THRESH (RW): [15:0] IRQ level threshold; exists only with the optional feature, otherwise reads 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Decimation:
  - The counter loads 0 when enable rises, on clear, and at reset.
  - On each adc_valid while enable=1 in IDLE: if counter==0, capture and reload counter with DECIM; else decrement.
  - Consequence: the first strobe after enable is always captured.
- FSM:
  - IDLE: on capture, snapshot adc_data and the mask, set idx=0, go to SCAN.
  - SCAN: one cycle per channel index. Push {idx, sample[idx]} if mask[idx]=1, else skip. Increment idx; at idx==NCH-1, return to IDLE in the next cycle.
  - Scan length is always NCH cycles. The first push occurs the cycle after adc_valid.
  - adc_valid during SCAN: sample dropped, overrun sticky set, decimation counter unchanged.
  - A zero mask still runs the scan but pushes nothing.
  - enable deasserted during SCAN: the scan completes; no new captures start.
- FIFO:
  - Push when full (judged on start-of-cycle level) is dropped and sets the overflow sticky, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full or empty: both occur, level unchanged.
  - Pointers wrap modulo DEPTH. level == DEPTH means full.
- Clear: in one cycle flushes the FIFO, forces IDLE, zeros the decimation counter and clears both stickies. Register contents are retained.
- Read path: avs_readdata updates on the cycle after avs_read; the DATA pop takes effect in the same edge.

Optional Feature:
- Macro ADC_MULTI_CAPTURE_IRQ_EN.
- Defined:
  - THRESH register exists.
  - irq registered high when (THRESH!=0 and level>=THRESH) or any sticky is set; it is low otherwise.
- Undefined: irq tied 0, address 4 reads 0 and ignores writes.

Decomposition:
- Package adc_multi_capture_pkg holds:
  - register address constants;
  - CTRL/STATUS bit offsets;
  - DATA field positions;
  - the FSM state enum (IDLE, SCAN).
- Sub-module adc_cap_fifo: synchronous FIFO (DEPTH, width 8+ADC_W) with push/pop/flush, level, full and empty.

Test Plan:
- Basic capture: NCH=4, mask=0xF, DECIM=0, one adc_valid with channels {0x123,0x456,0x789,0xABC} -> level 4; DATA reads 0x00000123, 0x01000456, 0x02000789, 0x03000ABC; then empty=1.
- Decimation and mask: DECIM=2, mask=0x5, 9 strobes -> only strobes 1, 4 and 7 captured; 6 entries, channels alternating 0, 2.
- Overrun: adc_valid on consecutive cycles -> second strobe dropped, STATUS bit19=1; writing 1 to bit19 clears it.
- Overflow: DEPTH=4, mask=0xF, two captures with no reads -> level 4, full=1, bit18=1; the first four entries are intact.
- Simultaneous pop/push and empty read: pop during a scan keeps the level consistent; DATA read on an empty FIFO returns 0 with level 0.
- Clear mid-scan and IRQ (feature on, THRESH=3): irq rises the cycle after level reaches 3; clear during SCAN -> level 0, IDLE, irq low.
